dmem_responder: RTL and testbench

Multi-cycle data-memory responder serving the load/store port of the pipelined MIPS32 core. It accepts the EX/MEM stage's `mem_read`/`mem_write` request, holds the pipeline via `stall` for a configurable number of wait states, then commits the store or returns load data. It replaces the single-cycle data memory and is the responder end of the pipeline's memory interface.

---
 rtl/mips_pkg.sv | 13 +
 rtl/dmem_wait_counter.sv | 27 ++
 rtl/dmem_responder.sv | 144 ++++++++++++++
 tb/tb_dmem_responder.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS32 core types and constants used by the data-memory responder.
package mips_pkg;

  localparam int unsigned WORD_W           = 32;
  localparam int unsigned DMEM_WAIT_CYCLES = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

endpackage

// File: rtl/dmem_wait_counter.sv
// Loadable down-counter that times the wait states of one data-memory access.
module dmem_wait_counter #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  // Saturates at zero so a stray enable can never wrap the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (en && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MIPS32 load/store port.
// Optional misaligned-access detection is enabled by defining DMEM_MISALIGN_CHECK_EN.
module dmem_responder
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = DMEM_WAIT_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [WORD_W-1:0] addr,
  input  logic [WORD_W-1:0] write_data,
  output logic [WORD_W-1:0] read_data,
  output logic              stall,
  output logic              done
`ifdef DMEM_MISALIGN_CHECK_EN
  ,
  output logic              misalign
`endif
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  dmem_state_t       state, state_next;
  logic              req;
  logic              accept, commit, cnt_en;
  logic [CNT_W-1:0]  cnt;
  logic              cnt_zero, cnt_last;
  logic              in_idle;
  logic              mis_in;
  logic              lat_write, lat_mis;
  logic [IDX_W-1:0]  lat_idx;
  logic [WORD_W-1:0] lat_data;
  logic              cur_write, cur_mis;
  logic [IDX_W-1:0]  cur_idx;
  logic [WORD_W-1:0] cur_data;
  logic [WORD_W-1:0] mem [DEPTH];
  logic              unused_addr;

  assign req         = mem_read | mem_write;
  assign stall       = req & (state != RESP);
  assign unused_addr = ^{addr[WORD_W-1:IDX_W+2], addr[1:0]};

`ifdef DMEM_MISALIGN_CHECK_EN
  assign mis_in = |addr[1:0];
`else
  assign mis_in = 1'b0;
`endif

  // With zero wait states the commit happens on the accept edge, so use the live request.
  assign in_idle   = (state == IDLE);
  assign cur_write = in_idle ? mem_write           : lat_write;
  assign cur_mis   = in_idle ? mis_in              : lat_mis;
  assign cur_idx   = in_idle ? addr[IDX_W+1:2]     : lat_idx;
  assign cur_data  = in_idle ? write_data          : lat_data;

  dmem_wait_counter #(
    .WIDTH(CNT_W)
  ) u_wait_counter (
    .clk        (clk),
    .reset      (reset),
    .load       (accept),
    .en         (cnt_en),
    .load_value (CNT_W'(WAIT_CYCLES)),
    .count      (cnt),
    .zero       (cnt_zero)
  );

  assign cnt_last = (cnt == CNT_W'(1));

  // Next-state and access strobes.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    commit     = 1'b0;
    cnt_en     = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            commit     = 1'b1;
            state_next = RESP;
          end else begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_en = 1'b1;
        if (cnt_last || cnt_zero) begin
          commit     = 1'b1;
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      done      <= 1'b0;
      read_data <= '0;
      lat_write <= 1'b0;
      lat_mis   <= 1'b0;
      lat_idx   <= '0;
      lat_data  <= '0;
`ifdef DMEM_MISALIGN_CHECK_EN
      misalign  <= 1'b0;
`endif
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      state <= state_next;
      done  <= commit;
`ifdef DMEM_MISALIGN_CHECK_EN
      misalign <= commit & cur_mis;
`endif
      if (accept) begin
        lat_write <= mem_write;
        lat_mis   <= mis_in;
        lat_idx   <= addr[IDX_W+1:2];
        lat_data  <= write_data;
      end
      // Store commits or load data lands on the edge that enters RESP.
      if (commit) begin
        if (cur_write) begin
          if (!cur_mis) begin
            mem[cur_idx] <= cur_data;
          end
        end else begin
          read_data <= cur_mis ? '0 : mem[cur_idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: two responders (2 and 0 wait states) against a transaction-level model.
module tb_dmem_responder;

  localparam int DEPTH = 256;
  localparam int WC [2] = '{2, 0};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rd [2];
  logic        wr [2];
  logic [31:0] ad [2];
  logic [31:0] wd [2];
  logic [31:0] rdata [2];
  logic        stl [2];
  logic        dn [2];
`ifdef DMEM_MISALIGN_CHECK_EN
  logic        mis [2];
`endif

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(2)) u_w2 (
    .clk(clk), .reset(reset), .mem_read(rd[0]), .mem_write(wr[0]),
    .addr(ad[0]), .write_data(wd[0]), .read_data(rdata[0]),
    .stall(stl[0]), .done(dn[0])
`ifdef DMEM_MISALIGN_CHECK_EN
    , .misalign(mis[0])
`endif
  );

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .reset(reset), .mem_read(rd[1]), .mem_write(wr[1]),
    .addr(ad[1]), .write_data(wd[1]), .read_data(rdata[1]),
    .stall(stl[1]), .done(dn[1])
`ifdef DMEM_MISALIGN_CHECK_EN
    , .misalign(mis[1])
`endif
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int stall_cnt [2] = '{0, 0};
  int done_cnt  [2] = '{0, 0};
  int mis_cnt   [2] = '{0, 0};

  // Model: one outstanding access per responder plus a word-addressed memory image.
  bit          busy  [2] = '{0, 0};
  int          start [2] = '{0, 0};
  bit          op_w  [2];
  logic [31:0] op_a  [2];
  logic [31:0] op_d  [2];
  logic [31:0] exp_rd [2] = '{32'h0, 32'h0};
  logic [31:0] mmem [2][DEPTH];

  task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d cyc=%0d: got %h expected %h", name, i, cyc, act, exp);
    end
  endtask

  function automatic bit is_mis(input logic [31:0] a);
`ifdef DMEM_MISALIGN_CHECK_EN
    return a[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        busy[i]   = 1'b0;
        exp_rd[i] = 32'h0;
        for (int j = 0; j < DEPTH; j++) mmem[i][j] = 32'h0;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        bit e_stall, e_done, e_mis;
        int k, idx;
        e_stall = 1'b0;
        e_done  = 1'b0;
        e_mis   = 1'b0;
        if (busy[i]) begin
          k = cyc - start[i];
          if (k <= WC[i]) begin
            e_stall = 1'b1;
          end else if (k == WC[i] + 1) begin
            e_done = 1'b1;
            e_mis  = is_mis(op_a[i]);
            idx    = int'((op_a[i] >> 2) % DEPTH);
            if (op_w[i]) begin
              if (!e_mis) mmem[i][idx] = op_d[i];
            end else begin
              exp_rd[i] = e_mis ? 32'h0 : mmem[i][idx];
            end
            busy[i] = 1'b0;
          end
        end
        chk("stall", i, 32'(stl[i]), 32'(e_stall));
        chk("done", i, 32'(dn[i]), 32'(e_done));
        chk("read_data", i, rdata[i], exp_rd[i]);
`ifdef DMEM_MISALIGN_CHECK_EN
        chk("misalign", i, 32'(mis[i]), 32'(e_mis));
        if (mis[i]) mis_cnt[i]++;
`endif
        if (stl[i]) stall_cnt[i]++;
        if (dn[i]) done_cnt[i]++;
      end
    end
  end

  task automatic present(input int i, input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
    rd[i] = r; wr[i] = w; ad[i] = a; wd[i] = d;
    busy[i] = 1'b1; start[i] = cyc; op_w[i] = w; op_a[i] = a; op_d[i] = d;
  endtask

  task automatic release_req(input int i);
    rd[i] = 1'b0; wr[i] = 1'b0; ad[i] = $urandom; wd[i] = $urandom;
  endtask

  // Called just after a rising edge; returns just after the edge that ends RESP.
  task automatic do_op(input int i, input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
    present(i, r, w, a, d);
    repeat (WC[i] + 2) @(posedge clk);
    #1;
    release_req(i);
  endtask

  task automatic rand_ops(input int i, input int n);
    for (int t = 0; t < n; t++) begin
      int kind;
      logic [31:0] a;
      kind = int'($urandom_range(0, 2));
      a = $urandom & 32'hFFFF_FC3C;
      if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom);
      do_op(i, kind != 1, kind != 0, a, $urandom);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    int c0;
    for (int i = 0; i < 2; i++) release_req(i);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_read_data", i, rdata[i], 32'h0);
      chk("rst_stall", i, 32'(stl[i]), 32'h0);
      chk("rst_done", i, 32'(dn[i]), 32'h0);
    end
    @(posedge clk);
    #1;

    do_op(0, 1, 0, 32'h10, 32'h0);
    chk("load_after_reset", 0, rdata[0], 32'h0);

    stall_cnt[0] = 0; done_cnt[0] = 0;
    do_op(0, 0, 1, 32'h20, 32'hDEADBEEF);
    chk("store_stalls", 0, 32'(stall_cnt[0]), 32'd3);
    stall_cnt[0] = 0; done_cnt[0] = 0;
    do_op(0, 1, 0, 32'h20, 32'h0);
    chk("load_stalls", 0, 32'(stall_cnt[0]), 32'd3);
    chk("load_dones", 0, 32'(done_cnt[0]), 32'd1);
    chk("load_deadbeef", 0, rdata[0], 32'hDEADBEEF);

    // Zero wait states, back-to-back loads
    do_op(1, 0, 1, 32'h4, 32'h0BADF00D);
    stall_cnt[1] = 0; done_cnt[1] = 0; c0 = cyc;
    do_op(1, 1, 0, 32'h0, 32'h0);
    do_op(1, 1, 0, 32'h4, 32'h0);
    chk("w0_stalls", 1, 32'(stall_cnt[1]), 32'd2);
    chk("w0_dones", 1, 32'(done_cnt[1]), 32'd2);
    chk("w0_cycles", 1, 32'(cyc - c0), 32'd4);
    chk("w0_read", 1, rdata[1], 32'h0BADF00D);

    // Address wrap-around
    do_op(0, 0, 1, 32'h400, 32'h12345678);
    do_op(0, 1, 0, 32'h000, 32'h0);
    chk("wrap", 0, rdata[0], 32'h12345678);

    // Simultaneous read and write is a write
    do_op(1, 1, 1, 32'h30, 32'hCAFE0001);
    chk("both_keeps_rd", 1, rdata[1], 32'h0BADF00D);
    do_op(1, 1, 0, 32'h30, 32'h0);
    chk("both_is_write", 1, rdata[1], 32'hCAFE0001);

    fork
      rand_ops(0, 120);
      rand_ops(1, 160);
    join

    // Reset in the middle of a store's wait states
    done_cnt[0] = 0;
    present(0, 1'b0, 1'b1, 32'h8, 32'hAAAA5555);
    @(posedge clk);
    #1;
    reset = 1'b1;
    release_req(0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_no_done", 0, 32'(done_cnt[0]), 32'd0);
    do_op(0, 1, 0, 32'h8, 32'h0);
    chk("reset_discard", 0, rdata[0], 32'h0);

`ifdef DMEM_MISALIGN_CHECK_EN
    do_op(0, 0, 1, 32'h20, 32'h00000077);
    mis_cnt[0] = 0;
    do_op(0, 0, 1, 32'h22, 32'h00000011);
    chk("mis_store_flag", 0, 32'(mis_cnt[0]), 32'd1);
    do_op(0, 1, 0, 32'h20, 32'h0);
    chk("mis_store_supp", 0, rdata[0], 32'h00000077);
    chk("mis_aligned_flag", 0, 32'(mis_cnt[0]), 32'd1);
    do_op(0, 1, 0, 32'h21, 32'h0);
    chk("mis_load_zero", 0, rdata[0], 32'h0);
    chk("mis_load_flag", 0, 32'(mis_cnt[0]), 32'd2);
`else
    do_op(0, 0, 1, 32'h22, 32'h00000011);
    do_op(0, 1, 0, 32'h21, 32'h0);
    chk("unaligned_ignored", 0, rdata[0], 32'h00000011);
`endif

    repeat (3) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
